// File: rtl/lipsi_pin_bridge.sv
// Lipsi core to TinyTapeout pin bridge: FIFO-buffered port writes streamed
// as header + data bytes on uo_out under a 4-phase req/ack handshake.
module lipsi_pin_bridge #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_full,
    output logic [7:0]        core_rdata,
    input  logic [7:0]        ui_in,
    output logic [7:0]        uo_out,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe
);

    localparam int BYTES = DATA_W / 8;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int IW    = $clog2(BYTES + 1);
    localparam int EW    = ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ,
        REL
    } state_t;

    state_t              state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [7:0]          ui_sync [SYNC_STAGES];
    logic                ack_s;

    logic [EW-1:0]       mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic                empty;
    logic                full;
    logic                pop;
    logic                push;
    logic                ovf;

    logic [EW-1:0]       rd_entry;
    logic [7:0]          hdr;
    logic [DATA_W-1:0]   sh;
    logic [IW-1:0]       idx;
    logic [7:0]          uo_q;
    logic                req;
    logic                sof;
    logic                busy;
    logic                unused_uio;

    assign unused_uio = ^{uio_in[7:5], uio_in[3:0]};

    // Pin inputs are asynchronous to clk; both paths see the same latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++)
                ui_sync[i] <= '0;
        end else begin
            ack_sync   <= {ack_sync[SYNC_STAGES-2:0], uio_in[4]};
            ui_sync[0] <= ui_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                ui_sync[i] <= ui_sync[i-1];
        end
    end

    assign ack_s      = ack_sync[SYNC_STAGES-1];
    assign core_rdata = ui_sync[SYNC_STAGES-1];

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign core_full = full;
    assign pop       = ena && (state == IDLE) && !empty && !ack_s;
    assign push      = core_wr && (!full || pop);

    assign rd_entry = mem[rd_ptr];
    assign hdr      = 8'(rd_entry[EW-1 -: ADDR_W]);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {core_addr, core_wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (core_wr && full && !pop)
                ovf <= 1'b1;
        end
    end

    // idx counts data bytes already placed on uo_out in this frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            uo_q  <= '0;
            req   <= 1'b0;
            sof   <= 1'b0;
            sh    <= '0;
            idx   <= '0;
        end else if (ena) begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        sh    <= rd_entry[DATA_W-1:0];
                        uo_q  <= hdr;
                        sof   <= 1'b1;
                        idx   <= '0;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    req   <= 1'b1;
                    state <= REQ;
                end
                REQ: begin
                    if (ack_s) begin
                        req   <= 1'b0;
                        state <= REL;
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        sof <= 1'b0;
                        if (idx == IW'(BYTES)) begin
                            state <= IDLE;
                        end else begin
                            uo_q  <= sh[DATA_W-1 -: 8];
                            sh    <= sh << 8;
                            idx   <= idx + IW'(1);
                            state <= SETUP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state != IDLE) || !empty;
    assign uo_out  = uo_q;
    assign uio_out = {4'b0000, busy, ovf, sof, req};
    assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_lipsi_pin_bridge.sv
// Bench for lipsi_pin_bridge: scoreboard of expected bus bytes checked
// against a host model that handshakes each req.
`timescale 1ns/1ps
module tb_lipsi_pin_bridge;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          core_wr = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_full;
    logic [7:0]    core_rdata;
    logic [7:0]    ui_in = 8'h00;
    logic [7:0]    uo_out;
    logic [7:0]    uio_in;
    logic [7:0]    uio_out;
    logic [7:0]    uio_oe;

    logic          ack = 1'b0;
    logic          host_en = 1'b0;
    logic [8:0]    sb [$];
    int            n_chk = 0;
    int            n_pass = 0;

    assign uio_in = {3'b000, ack, 4'b0000};

    always #5 clk = ~clk;

    lipsi_pin_bridge #(
        .DATA_W(DW), .DEPTH(4), .ADDR_W(AW), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_full(core_full),
        .core_rdata(core_rdata), .ui_in(ui_in),
        .uo_out(uo_out), .uio_in(uio_in),
        .uio_out(uio_out), .uio_oe(uio_oe)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit expect_frame);
        core_wr    = 1'b1;
        core_addr  = a;
        core_wdata = d;
        if (expect_frame) begin
            sb.push_back({1'b1, 8'(a)});
            for (int i = NB - 1; i >= 0; i--)
                sb.push_back({1'b0, d[i*8 +: 8]});
        end
        @(negedge clk);
        core_wr = 1'b0;
    endtask

    task automatic wait_req(input logic lvl, input string tag);
        for (int i = 0; i < 40 && uio_out[0] !== lvl; i++)
            @(negedge clk);
        chk(tag, uio_out[0], lvl);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0 && uio_out[3] === 1'b0)
                break;
            @(negedge clk);
        end
        chk(tag, {sb.size() == 0, uio_out[3]}, 2'b10);
    endtask

    // Host: on each fresh req, check the byte then ack after 2 cycles.
    initial begin : host
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (host_en && uio_out[0] === 1'b1 && !ack) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", uo_out, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("byte", uo_out, e[7:0]);
                    chk("sof", uio_out[1], e[8]);
                end
                repeat (2) @(negedge clk);
                ack = 1'b1;
                for (int i = 0; i < 40 && uio_out[0] === 1'b1; i++)
                    @(negedge clk);
                chk("req_drop", uio_out[0], 1'b0);
                ack = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        // Reset state with ack high and inputs driven.
        ack   = 1'b1;
        ui_in = 8'hA5;
        repeat (3) @(negedge clk);
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'h0F);
        chk("rst_rdata", core_rdata, 8'h00);
        chk("rst_full", core_full, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("sync1", core_rdata, 8'h00);
        @(negedge clk);
        chk("sync2", core_rdata, 8'hA5);
        ack = 1'b0;
        repeat (4) @(negedge clk);

        // Single frame with latency checks.
        wr(3'd3, 16'hBEEF, 1'b1);
        chk("t1_req", uio_out[0], 1'b0);
        chk("t1_busy", uio_out[3], 1'b1);
        @(negedge clk);
        chk("t2_hdr", uo_out, 8'h03);
        chk("t2_sof", uio_out[1], 1'b1);
        chk("t2_req", uio_out[0], 1'b0);
        @(negedge clk);
        chk("t3_req", uio_out[0], 1'b1);
        host_en = 1'b1;
        wait_idle("frame_done");

        // Full FIFO with a write in the popping cycle.
        ena = 1'b0;
        for (int i = 0; i < 4; i++)
            wr(3'(i), 16'h1100 + 16'(i), 1'b1);
        chk("fill_full", core_full, 1'b1);
        ena = 1'b1;
        wr(3'd7, 16'hA55A, 1'b1);
        chk("pop_push_ovf", uio_out[2], 1'b0);
        chk("pop_push_full", core_full, 1'b1);
        wait_idle("drain5");

        // Overflow: fifth write dropped.
        ena = 1'b0;
        for (int i = 0; i < 4; i++)
            wr(3'(i + 2), 16'h2200 + 16'(i * 3), 1'b1);
        wr(3'd1, 16'hDEAD, 1'b0);
        chk("ovf_full", core_full, 1'b1);
        chk("ovf_set", uio_out[2], 1'b1);
        ena = 1'b1;
        wait_idle("drain4");
        chk("ovf_sticky", uio_out[2], 1'b1);

        // Freeze mid-REQ with an ack pulse.
        host_en = 1'b0;
        wr(3'd5, 16'h1234, 1'b1);
        wait_req(1'b1, "frz_req");
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("frz_req_hold", uio_out[0], 1'b1);
            chk("frz_uo_hold", uo_out, 8'h05);
            ack = (i < 2);
        end
        ack = 1'b0;
        ena = 1'b1;
        repeat (3) @(negedge clk);
        chk("resume_req", uio_out[0], 1'b1);
        host_en = 1'b1;
        wait_idle("frz_done");

        // Reset mid-frame during byte 1.
        host_en = 1'b0;
        wr(3'd6, 16'hCAFE, 1'b0);
        wait_req(1'b1, "r6_req0");
        chk("r6_hdr", uo_out, 8'h06);
        ack = 1'b1;
        wait_req(1'b0, "r6_rel0");
        ack = 1'b0;
        wait_req(1'b1, "r6_req1");
        chk("r6_b1", uo_out, 8'hCA);
        chk("r6_sof", uio_out[1], 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("r6_async_req", uio_out[0], 1'b0);
        chk("r6_async_uo", uo_out, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("r6_idle", uio_out, 8'h00);
        chk("r6_full", core_full, 1'b0);
        chk("r6_sb", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
